// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   One pipelined signed Q1.(BITSIZE-1) multiplier shared by NREQ requesters
//   on the fast system clock. A round-robin arbiter grants one requester per
//   cycle, captures its operands, and the product comes back PIPE cycles later
//   with a one-hot res_valid pulse that identifies its owner.
//
// Optional feature (compile-time macro): MULT_ARB_ROUND_EN
//   Defined   : round half up (add 2^(BITSIZE-2) before the shift).
//   Undefined : plain truncation toward -inf. Latency is the same in both.
//
// Ports
//   clk        system clock, single domain
//   rst        synchronous active-high reset
//   req        per-requester request
//   op_a/op_b  operands, requester i at [i*BITSIZE +: BITSIZE], signed
//   gnt        one-hot 1-cycle pulse: operands of i captured this cycle
//   res_valid  one-hot 1-cycle pulse: result belongs to requester i
//   result     signed product, zero unless res_valid != 0
//   busy       1 while any product is in flight
//
// Handshake: req[i] is held high with stable operands until gnt[i] is seen.
// gnt[i] marks the cycle the operands were taken; a req[i] still high when
// the next clock edge samples it counts as a fresh request. Dropping req[i]
// before gnt[i] withdraws the request with no grant and no result.
module mult_share_arbiter #(
  parameter int BITSIZE = 16,
  parameter int NREQ    = 4,
  parameter int PIPE    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*BITSIZE-1:0]   op_a,
  input  logic [NREQ*BITSIZE-1:0]   op_b,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           res_valid,
  output logic [BITSIZE-1:0]        result,
  output logic                      busy
);

  localparam int PW = $clog2(NREQ);
  localparam int DW = 2 * BITSIZE;

  // Largest representable positive result, sign-extended to product width.
  localparam logic signed [DW-1:0] MAXQ =
    {{(DW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};

  // ---------------- round-robin arbiter ----------------
  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;
  logic [PW-1:0] win_idx;
  logic          win_valid;

  // Search starts at ptr; the first requester found keeps the win.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      gnt <= '0;
    end else begin
      gnt <= win_valid ? (NREQ'(1) << win_idx) : '0;
      if (win_valid) begin
        ptr <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // ---------------- stage 0: operand capture ----------------
  logic                      s0_v;
  logic [PW-1:0]             s0_tag;
  logic signed [BITSIZE-1:0] s0_a;
  logic signed [BITSIZE-1:0] s0_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v   <= 1'b0;
      s0_tag <= '0;
      s0_a   <= '0;
      s0_b   <= '0;
    end else begin
      s0_v <= win_valid;
      if (win_valid) begin
        s0_tag <= win_idx;
        s0_a   <= op_a[int'(win_idx)*BITSIZE +: BITSIZE];
        s0_b   <= op_b[int'(win_idx)*BITSIZE +: BITSIZE];
      end
    end
  end

  logic signed [DW-1:0] m_p;
  assign m_p = s0_a * s0_b;

  // ---------------- product delay line ----------------
  // Stage 0 plus PIPE-1 product stages plus the output register give exactly
  // PIPE cycles from the gnt cycle to the res_valid cycle.
  logic                 last_v;
  logic [PW-1:0]        last_tag;
  logic signed [DW-1:0] last_p;
  logic                 line_busy;

  generate
    if (PIPE > 1) begin : g_line
      logic                 pv   [PIPE-1];
      logic [PW-1:0]        ptag [PIPE-1];
      logic signed [DW-1:0] pp   [PIPE-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < PIPE-1; s++) begin
            pv[s]   <= 1'b0;
            ptag[s] <= '0;
            pp[s]   <= '0;
          end
        end else begin
          pv[0]   <= s0_v;
          ptag[0] <= s0_tag;
          pp[0]   <= m_p;
          for (int s = 1; s < PIPE-1; s++) begin
            pv[s]   <= pv[s-1];
            ptag[s] <= ptag[s-1];
            pp[s]   <= pp[s-1];
          end
        end
      end

      always_comb begin
        line_busy = 1'b0;
        for (int s = 0; s < PIPE-1; s++) begin
          line_busy = line_busy | pv[s];
        end
      end

      assign last_v   = pv[PIPE-2];
      assign last_tag = ptag[PIPE-2];
      assign last_p   = pp[PIPE-2];
    end else begin : g_direct
      assign line_busy = 1'b0;
      assign last_v    = s0_v;
      assign last_tag  = s0_tag;
      assign last_p    = m_p;
    end
  endgenerate

  assign busy = s0_v | line_busy;

  // ---------------- scale, round, saturate ----------------
  logic signed [DW-1:0] adj_p;
  logic signed [DW-1:0] q;
  logic [BITSIZE-1:0]   scaled;

`ifdef MULT_ARB_ROUND_EN
  localparam logic signed [DW-1:0] HALF =
    {{(DW-BITSIZE+1){1'b0}}, 1'b1, {(BITSIZE-2){1'b0}}};
  assign adj_p = last_p + HALF;
`else
  assign adj_p = last_p;
`endif

  // Only (-1)*(-1) can exceed the positive range; clamp instead of wrapping.
  always_comb begin
    q      = adj_p >>> (BITSIZE-1);
    scaled = (q > MAXQ) ? {1'b0, {(BITSIZE-1){1'b1}}} : q[BITSIZE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= '0;
      result    <= '0;
    end else begin
      res_valid <= last_v ? (NREQ'(1) << last_tag) : '0;
      result    <= last_v ? scaled : '0;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter (BITSIZE=16, NREQ=4, PIPE=2).
// A cycle monitor keeps a reference round-robin pointer and an expected
// result queue; directed steps drive the stimulus and add constant checks.
module tb_mult_share_arbiter;

  localparam int BITSIZE = 16;
  localparam int NREQ    = 4;
  localparam int PIPE    = 2;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*BITSIZE-1:0] op_a;
  logic [NREQ*BITSIZE-1:0] op_b;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         res_valid;
  logic [BITSIZE-1:0]      result;
  logic                    busy;

  int total = 0;
  int bad   = 0;

  // {due cycle[63:32], tag[31:16], result[15:0]}
  logic [63:0] exp_q[$];

  mult_share_arbiter #(.BITSIZE(BITSIZE), .NREQ(NREQ), .PIPE(PIPE)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .res_valid(res_valid), .result(result), .busy(busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Q1.15 product from the arithmetic definition.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint qv;
    logic [63:0] qbits;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef MULT_ARB_ROUND_EN
    p = p + 64'sd16384;
`endif
    qv = p >>> 15;
    if (qv > 64'sd32767) qv = 64'sd32767;
    qbits = qv;
    return qbits[15:0];
  endfunction

  // ---------------- cycle monitor / scoreboard ----------------
  int          cyc  = 0;
  int          mptr = 0;
  logic [3:0]  m_req;
  logic        m_rst;
  logic [63:0] m_a;
  logic [63:0] m_b;
  logic [63:0] m_e;
  int          m_win;
  int          m_idx;

  always @(posedge clk) begin
    m_req = req;
    m_rst = rst;
    m_a   = op_a;
    m_b   = op_b;
    cyc++;
    #1;
    if (m_rst) begin
      exp_q.delete();
      mptr = 0;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end else begin
      if (exp_q.size() > 0 && exp_q[0][63:32] == 32'(cyc)) begin
        m_e = exp_q.pop_front();
        check("res_valid", 32'(res_valid), 32'd1 << m_e[31:16]);
        check("result", 32'(result), 32'(m_e[15:0]));
      end else begin
        check("res_valid_idle", 32'(res_valid), 32'd0);
      end
      m_win = -1;
      for (int k = 0; k < NREQ; k++) begin
        m_idx = (mptr + k) % NREQ;
        if (m_win < 0 && m_req[m_idx]) m_win = m_idx;
      end
      check("gnt", 32'(gnt), (m_win >= 0) ? (32'd1 << m_win) : 32'd0);
      if (m_win >= 0) begin
        exp_q.push_back({32'(cyc + PIPE), 16'(m_win),
                         model(m_a[m_win*16 +: 16], m_b[m_win*16 +: 16])});
        mptr = (m_win + 1) % NREQ;
      end
      check("busy", 32'(busy), 32'(exp_q.size() > 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    op_a[i*16 +: 16] = a;
    op_b[i*16 +: 16] = b;
  endtask

  // Issue one product for requester i and check grant, latency and value.
  task automatic single(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] expv, input string name);
    int n;
    bit seen;
    @(negedge clk);
    set_ops(i, a, b);
    req[i] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (gnt[i]) seen = 1'b1;
    end
    req[i] = 1'b0;
    check({name, "_gnt_seen"}, 32'(seen), 32'd1);
    n = 0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      n++;
      if (res_valid[i]) seen = 1'b1;
    end
    check({name, "_res_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(PIPE));
    check({name, "_value"}, 32'(result), 32'(expv));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst  = 1'b1;
    req  = '0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(negedge clk);
    check("init_gnt", 32'(gnt), 32'd0);
    check("init_res_valid", 32'(res_valid), 32'd0);
    check("init_result", 32'(result), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Basic product: 0.5 * 0.5
    single(0, 16'h4000, 16'h4000, 16'h2000, "t1");

    // Round-robin order with all requesters held, starting from ptr=0
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t2_order", 32'(gnt), 32'd1 << (k % NREQ));
    end
    req = 4'b0000;
    check("t2_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);

    // Saturation and extreme operands
    single(1, 16'h8000, 16'h8000, 16'h7FFF, "t3_sat");
    single(2, 16'h8000, 16'h7FFF, 16'h8001, "t3_minmax");
    single(3, 16'h7FFF, 16'h7FFF, 16'h7FFE, "t3_maxmax");

    // LSB behaviour: truncation vs rounding
`ifdef MULT_ARB_ROUND_EN
    single(0, 16'h0001, 16'h4000, 16'h0001, "t4_half");
    single(0, 16'hFFFF, 16'h4000, 16'h0000, "t4_neg_half");
`else
    single(0, 16'h0001, 16'h4000, 16'h0000, "t4_half");
    single(0, 16'hFFFF, 16'h4000, 16'hFFFF, "t4_neg_half");
`endif

    // Reset one cycle after three grants: everything in flight is dropped
    @(negedge clk);
    req = 4'b0111;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_res_valid", 32'(res_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_gnt", 32'(gnt), 32'd0);
    rst = 1'b0;
    req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_result", 32'(res_valid), 32'd0);
    end

    // Withdrawal; grant to 0 first also shows ptr returned to 0
    set_ops(0, 16'h2000, 16'h2000);
    set_ops(2, 16'h1234, 16'h4321);
    req = 4'b0101;
    @(negedge clk);
    check("t5_first_gnt", 32'(gnt), 32'd1);
    req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_no_gnt2", 32'(gnt[2]), 32'd0);
      check("t5_no_res2", 32'(res_valid[2]), 32'd0);
    end

    // Random traffic with corner operands mixed in
    for (int k = 0; k < 300; k++) begin
      req = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0:       op_a[i*16 +: 16] = 16'h8000;
          1:       op_a[i*16 +: 16] = 16'h7FFF;
          default: op_a[i*16 +: 16] = 16'($urandom_range(0, 65535));
        endcase
        case ($urandom_range(0, 3))
          0:       op_b[i*16 +: 16] = 16'h8000;
          1:       op_b[i*16 +: 16] = 16'hFFFF;
          default: op_b[i*16 +: 16] = 16'($urandom_range(0, 65535));
        endcase
      end
      @(negedge clk);
    end
    req = 4'b0000;
    repeat (PIPE + 4) @(negedge clk);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
